// File: rtl/regfile_access_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// regfile_access_ctrl_pkg: shared widths, reserved register ids, FSM states
// Rev 1.0
// ==========================================================================
package regfile_access_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int NREG   = 16;
    localparam int ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;
    localparam logic [ADDR_W-1:0] REG_RSVD = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    // R0 and R15 are write-dropped by the bank, so they never carry a pending write
    function automatic logic is_tracked(input logic [ADDR_W-1:0] r);
        return (r != REG_ZERO) && (r != REG_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_access_ctrl_if.sv
`default_nettype none
// ==========================================================================
// regfile_access_ctrl_if: decode/execute/writeback/bank signal bundle
// Rev 1.0
// ==========================================================================
interface regfile_access_ctrl_if;
    import regfile_access_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs1;
    logic [ADDR_W-1:0] req_rs2;
    logic [ADDR_W-1:0] req_rd;
    logic              req_wen;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] op_rd;
    logic              op_wen;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic [ADDR_W-1:0] rf_rs1;
    logic [ADDR_W-1:0] rf_rs2;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_reg_write;

    logic [NREG-1:0]   busy;
    logic              wb_err;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd, req_wen,
        input  op_ready, wb_valid, wb_rd, wb_data, rf_data1, rf_data2,
        output req_ready, op_valid, op_a, op_b, op_rd, op_wen,
        output rf_rs1, rf_rs2, rf_rd, rf_write_data, rf_reg_write, busy, wb_err
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_rd, req_wen,
        output op_ready, wb_valid, wb_rd, wb_data, rf_data1, rf_data2,
        input  req_ready, op_valid, op_a, op_b, op_rd, op_wen,
        input  rf_rs1, rf_rs2, rf_rd, rf_write_data, rf_reg_write, busy, wb_err
    );

endinterface
`default_nettype wire

// File: rtl/regfile_access_ctrl_reg_scoreboard.sv
`default_nettype none
// ==========================================================================
// reg_scoreboard: pending-write busy vector, RAW/WAW hazard, writeback error
// Rev 1.0
// ==========================================================================
module reg_scoreboard
    import regfile_access_ctrl_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              set_en,
    input  wire logic [ADDR_W-1:0] set_rd,
    input  wire logic              clr_en,
    input  wire logic [ADDR_W-1:0] clr_rd,
    input  wire logic [ADDR_W-1:0] rs1,
    input  wire logic [ADDR_W-1:0] rs2,
    input  wire logic [ADDR_W-1:0] rd,
    input  wire logic              wen,
    output logic [NREG-1:0]        busy,
    output logic                   hazard,
    output logic                   wb_err
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && is_tracked(set_rd)) begin
            set_mask[set_rd] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_rd] = 1'b1;
        end
    end

    assign hazard = busy[rs1] | busy[rs2] | (wen & busy[rd]);

    // Clear lands on the same edge the bank commits, so a reader released
    // by it issues its negedge read after the data is in the bank.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (clr_en && !busy[clr_rd] && is_tracked(clr_rd)) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ==========================================================================
// regfile_access_ctrl: operand fetch from the 16x32 bank with hazard stalls
// Rev 1.0
// ==========================================================================
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    regfile_access_ctrl_if.slave bus
);

    state_t state;
    state_t state_nxt;
    logic   hazard;
    logic   accept;

    assign accept = (state == IDLE) & bus.req_valid & ~hazard;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.op_valid  = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = ~hazard;
                if (bus.req_valid && !hazard) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                bus.op_valid = 1'b1;
                if (bus.op_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // rf_data is launched by the bank on the negedge inside READ
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            bus.rf_rs1 <= '0;
            bus.rf_rs2 <= '0;
            bus.op_rd  <= '0;
            bus.op_wen <= 1'b0;
            bus.op_a   <= '0;
            bus.op_b   <= '0;
        end else begin
            if (accept) begin
                bus.rf_rs1 <= bus.req_rs1;
                bus.rf_rs2 <= bus.req_rs2;
                bus.op_rd  <= bus.req_rd;
                bus.op_wen <= bus.req_wen;
            end
            if (state == READ) begin
                bus.op_a <= bus.rf_data1;
                bus.op_b <= bus.rf_data2;
            end
        end
    end

    assign bus.rf_reg_write  = bus.wb_valid;
    assign bus.rf_rd         = bus.wb_rd;
    assign bus.rf_write_data = bus.wb_data;

    reg_scoreboard u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (accept & bus.req_wen),
        .set_rd (bus.req_rd),
        .clr_en (bus.wb_valid),
        .clr_rd (bus.wb_rd),
        .rs1    (bus.req_rs1),
        .rs2    (bus.req_rs2),
        .rd     (bus.req_rd),
        .wen    (bus.req_wen),
        .busy   (bus.busy),
        .hazard (hazard),
        .wb_err (bus.wb_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_regfile_access_ctrl: bank model, random/directed stimulus, scoreboard
// Rev 1.0
// ==========================================================================
module tb_regfile_access_ctrl;
    import regfile_access_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_access_ctrl_if bus ();

    regfile_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 0 || i == 15) return 32'd0;
        if (i == 3) return 32'd5;
        if (i == 4) return 32'd7;
        return 32'h1357_0000 + 32'(i * 97);
    endfunction

    // Behavioural bank: posedge write (R0/R15 dropped), negedge-registered reads
    logic [31:0] bank [16];
    bit          bank_loaded = 1'b0;
    always @(posedge clk) begin
        if (!bank_loaded) begin
            for (int i = 0; i < 16; i++) bank[i] <= init_val(i);
            bank_loaded <= 1'b1;
        end else if (bus.rf_reg_write && bus.rf_rd != 4'd0 && bus.rf_rd != 4'd15) begin
            bank[bus.rf_rd] <= bus.rf_write_data;
        end
    end
    always @(negedge clk) begin
        bus.rf_data1 <= bank[bus.rf_rs1];
        bus.rf_data2 <= bank[bus.rf_rs2];
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_mem [16];
    logic [15:0] exp_busy = '0;
    logic        exp_err  = 1'b0;
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, acc_cyc = 0;
    logic        prev_opv = 1'b0;

    int          rdy_mode = 1;
    bit          wb_auto  = 1'b0;
    bit          dir_wb   = 1'b0;
    logic [3:0]  dir_rd   = '0;
    logic [31:0] dir_data = '0;
    logic        s_hs, s_ophs, s_opv, s_rdy;
    logic [31:0] s_opa, s_opb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: samples at negedge, compares DUT outputs against the model,
    // then advances the model by what happened in this cycle.
    task automatic monitor();
        exp_t        e;
        logic [15:0] nxt;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_q.delete();
                exp_busy = '0;
                exp_err  = 1'b0;
                prev_opv = 1'b0;
                continue;
            end
            cyc++;
            chk("busy", 64'(bus.busy), 64'(exp_busy));
            chk("wb_err", 64'(bus.wb_err), 64'(exp_err));
            chk("rf_write_port", {27'd0, bus.rf_reg_write, bus.rf_rd, bus.rf_write_data},
                {27'd0, bus.wb_valid, bus.wb_rd, bus.wb_data});
            if (bus.req_valid && (exp_busy[bus.req_rs1] || exp_busy[bus.req_rs2] ||
                                  (bus.req_wen && exp_busy[bus.req_rd])))
                chk("hazard_stall", 64'(bus.req_ready), 64'd0);
            if (bus.op_valid && !prev_opv)
                chk("latency", 64'(cyc - acc_cyc), 64'd2);
            if (bus.op_valid && bus.op_ready) begin
                if (exp_q.size() == 0) begin
                    chk("op_unexpected", 64'(bus.op_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("op_a", 64'(bus.op_a), 64'(e.a));
                    chk("op_b", 64'(bus.op_b), 64'(e.b));
                    chk("op_rd_wen", 64'({bus.op_rd, bus.op_wen}), 64'({e.rd, e.wen}));
                end
            end
            nxt = exp_busy;
            if (bus.wb_valid) begin
                if (!exp_busy[bus.wb_rd] && bus.wb_rd != 4'd0 && bus.wb_rd != 4'd15) exp_err = 1'b1;
                nxt[bus.wb_rd] = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                e.a   = ref_mem[bus.req_rs1];
                e.b   = ref_mem[bus.req_rs2];
                e.rd  = bus.req_rd;
                e.wen = bus.req_wen;
                exp_q.push_back(e);
                acc_cyc = cyc;
                if (bus.req_wen && bus.req_rd != 4'd0 && bus.req_rd != 4'd15) nxt[bus.req_rd] = 1'b1;
            end
            exp_busy = nxt;
            prev_opv = bus.op_valid;
        end
    endtask

    task automatic drive_wb(input logic [3:0] rd, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
        if (rd != 4'd0 && rd != 4'd15) ref_mem[rd] = data;
    endtask

    // One clock: sample at negedge, drive next-cycle inputs 1 time unit after posedge
    task automatic cycle();
        int r;
        @(negedge clk);
        s_hs   = bus.req_valid & bus.req_ready;
        s_ophs = bus.op_valid & bus.op_ready;
        s_opv  = bus.op_valid;
        s_rdy  = bus.req_ready;
        s_opa  = bus.op_a;
        s_opb  = bus.op_b;
        @(posedge clk);
        #1;
        if (s_hs) bus.req_valid = 1'b0;
        case (rdy_mode)
            0:       bus.op_ready = 1'b0;
            1:       bus.op_ready = 1'b1;
            default: bus.op_ready = ($urandom_range(0, 3) != 0);
        endcase
        bus.wb_valid = 1'b0;
        if (dir_wb) begin
            drive_wb(dir_rd, dir_data);
            dir_wb = 1'b0;
        end else if (wb_auto && exp_busy != '0 && $urandom_range(0, 1) == 1) begin
            do r = $urandom_range(1, 14); while (!exp_busy[r]);
            drive_wb(4'(r), $urandom);
        end
    endtask

    task automatic do_req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                          input logic wen, output int n);
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_rd    = rd;
        bus.req_wen   = wen;
        bus.req_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_hs && n < 400);
        chk("req_accept", 64'(s_hs), 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_op(input string name, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_opv && n < 10);
        chk(name, {s_opa, s_opb}, {a, b});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] a0, b0;
        bus.req_valid = 1'b0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
        bus.req_rd    = '0;
        bus.req_wen   = 1'b0;
        bus.op_ready  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        fork
            monitor();
        join_none
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {bus.op_valid, bus.busy, bus.wb_err, bus.req_ready, bus.rf_rs1, bus.rf_rs2},
            {1'b0, 16'h0, 1'b0, 1'b1, 4'h0, 4'h0});
        chk("rst_op", {bus.op_a, bus.op_rd, bus.op_wen}, 64'd0);
        rst_n = 1'b0;

        // Basic read with 2-cycle latency
        do_req(4'd3, 4'd4, 4'd0, 1'b0, n);
        expect_op("read_r3_r4", 32'd5, 32'd7);

        // RAW stall released by writeback the cycle after
        do_req(4'd0, 4'd0, 4'd5, 1'b1, n);
        expect_op("issue_rd5", 32'd0, 32'd0);
        bus.req_rs1 = 4'd5; bus.req_rs2 = 4'd0; bus.req_rd = 4'd0; bus.req_wen = 1'b0;
        bus.req_valid = 1'b1;
        repeat (4) begin
            cycle();
            chk("raw_stall", 64'(s_hs), 64'd0);
        end
        dir_rd = 4'd5; dir_data = 32'hDEAD_BEEF; dir_wb = 1'b1;
        cycle();
        cycle();
        chk("raw_stall_wb_cycle", 64'(s_hs), 64'd0);
        cycle();
        chk("raw_accept_next", 64'(s_hs), 64'd1);
        bus.req_valid = 1'b0;
        expect_op("raw_data", 32'hDEAD_BEEF, 32'd0);

        // R0/R15 destinations never become busy
        do_req(4'd0, 4'd0, 4'd0, 1'b1, n);
        expect_op("wr_r0", 32'd0, 32'd0);
        do_req(4'd0, 4'd0, 4'd15, 1'b1, n);
        expect_op("wr_r15", 32'd0, 32'd0);
        chk("busy_r0_r15", 64'(bus.busy), 64'd0);
        do_req(4'd0, 4'd15, 4'd0, 1'b0, n);
        chk("r0_no_stall", 64'(n), 64'd1);
        expect_op("read_r0_r15", 32'd0, 32'd0);

        // Backpressure in HOLD for 5 cycles, release on the 6th
        rdy_mode = 0;
        do_req(4'd3, 4'd4, 4'd0, 1'b0, n);
        cycle();
        cycle();
        chk("hold_valid", 64'(s_opv), 64'd1);
        a0 = s_opa;
        b0 = s_opb;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) rdy_mode = 1;
            cycle();
            chk("hold_stable", {s_opv, s_opa, s_opb[30:0]}, {1'b1, a0, b0[30:0]});
            chk("hold_not_ready", 64'(s_rdy), 64'd0);
        end
        cycle();
        chk("hold_release", 64'(s_ophs), 64'd1);
        cycle();
        chk("idle_after_hold", 64'(s_rdy), 64'd1);

        // Writeback to a non-busy register
        dir_rd = 4'd7; dir_data = 32'h0BAD_F00D; dir_wb = 1'b1;
        cycle();
        #1;
        chk("wb_err_fwd", {bus.rf_reg_write, bus.rf_rd}, {1'b1, 4'd7});
        cycle();
        chk("wb_err_set", 64'(bus.wb_err), 64'd1);
        repeat (3) cycle();
        chk("wb_err_sticky", 64'(bus.wb_err), 64'd1);

        // Asynchronous reset while in READ with a pending write
        do_req(4'd0, 4'd0, 4'd5, 1'b1, n);
        expect_op("issue_rd5_again", 32'd0, 32'd0);
        do_req(4'd1, 4'd2, 4'd0, 1'b0, n);
        chk("pre_rst_busy5", 64'(bus.busy[5]), 64'd1);
        rst_n = 1'b1;
        #1;
        chk("async_rst", {bus.op_valid, bus.busy, bus.wb_err, bus.req_ready, bus.rf_rs1, bus.rf_rs2},
            {1'b0, 16'h0, 1'b0, 1'b1, 4'h0, 4'h0});
        chk("async_rst_op", {bus.op_a, bus.op_rd, bus.op_wen}, 64'd0);
        cycle();
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("post_rst_no_op", 64'(s_opv), 64'd0);

        // Randomized traffic with background writebacks and backpressure
        rdy_mode = 2;
        wb_auto  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            do_req(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), n);
        end
        rdy_mode = 1;
        repeat (40) cycle();
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Initiator-side controller for the 16×32 register bank. It accepts decoded operand requests, drives the bank's read and write ports, and captures operands from the bank's negedge-registered read outputs. It tracks pending destination writes in a busy scoreboard and stalls read-after-write and write-after-write hazards. It sits between decode and execute; writeback returns through it to the bank.

## Interface
- DATA_W, 32, register data width
- NREG, 16, register count (address width 4)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (naming notwithstanding)
- req_valid / req_ready  in / out  1 / 1  request handshake from decode
- req_rs1, req_rs2, req_rd  in  4 each  source and destination addresses
- req_wen  in  1  request will write req_rd
- op_valid / op_ready  out / in  1 / 1  operand handshake to execute
- op_a, op_b  out  32 each  captured operands
- op_rd  out  4  forwarded destination
- op_wen  out  1  forwarded write flag
- wb_valid  in  1  writeback strobe; always accepted, no ready
- wb_rd  in  4  writeback destination
- wb_data  in  32  writeback data
- rf_rs1, rf_rs2  out  4 each  bank read addresses
- rf_data1, rf_data2  in  32 each  bank read data, registered by the bank on negedge
- rf_rd, rf_write_data, rf_reg_write  out  4 / 32 / 1  bank write port
- busy  out  16  scoreboard, bit i set means write to Ri pending
- wb_err  out  1  sticky flag for writeback to a non-busy register

## Operation
- FSM states: IDLE, READ, HOLD. Reset state is IDLE.
- Hazard (combinational): busy[req_rs1] | busy[req_rs2] | (req_wen & busy[req_rd]). Bit 0 of busy is never set.
- req_ready = (state==IDLE) & ~hazard. req_ready depends combinationally on the req_* inputs.
- IDLE, on req handshake:
  - register rf_rs1/rf_rs2 ← rs1/rs2; op_rd ← rd; op_wen ← wen.
  - set busy[rd] if wen and rd∉{0,15}.
  - go to READ.
- READ: lasts exactly one cycle. The bank captures on the mid-cycle negedge. At the closing posedge, op_a ← rf_data1, op_b ← rf_data2, op_valid ← 1, go to HOLD.
- HOLD: op_* are held stable until op_valid & op_ready. On that handshake, op_valid ← 0 and go to IDLE.
- Writeback path (combinational pass-through): rf_reg_write = wb_valid, rf_rd = wb_rd, rf_write_data = wb_data.
- Busy clear: on wb_valid, busy[wb_rd] clears at the same posedge at which the bank commits the write.
- wb_valid with busy[wb_rd]==0 and wb_rd∉{0,15} sets wb_err. The write is still forwarded.
- Writes to R0/R15 are forwarded, are dropped by the bank, and never touch busy.
- Same-cycle wb clear and issue set never target the same bit: the WAW stall prevents it. Clear and set on different bits both take effect.

## Timing
- Accept at posedge T, op_valid high after posedge T+2 (2-cycle latency). Best-case throughput is one request per 3 cycles.
- wb_valid in cycle N: busy bit drops after posedge N+1, so a stalled reader is accepted no earlier than cycle N+1.
  - Its negedge read then sees the written value.
  - A read issued in cycle N itself would see the stale value; the stall forbids this.
- Reset (asynchronous, any state including READ/HOLD):
  - state IDLE; busy 0; wb_err 0; op_valid 0.
  - op_a, op_b, op_rd, op_wen 0; rf_rs1, rf_rs2 0.
  - In-flight request is discarded.

## Structure
- Shared package: DATA_W, NREG, REG_ZERO=4'd0, REG_RSVD=4'd15, FSM state enum.
- Sub-module reg_scoreboard: busy vector, set/clear ports, hazard compare, wb_err generation.

## Test plan
- Bank R3=5, R4=7. Request rs1=3, rs2=4, accepted at T → op_valid after T+2, op_a=5, op_b=7.
- Issue rd=5 wen=1, then request rs1=5 → req_ready=0 until wb_valid rd=5 data=0xDEADBEEF. Read accepted the next cycle; op_a=0xDEADBEEF.
- Issue rd=0 and rd=15 with wen=1 → busy stays 16'h0000. Following read of r0 is not stalled and returns 0.
- op_ready low 5 cycles in HOLD → op_a/op_b stable, req_ready=0. Handshake on cycle 6 → IDLE next cycle.
- wb_valid rd=7 with busy[7]=0 → wb_err=1, stays 1 until reset; rf_reg_write still pulses.
- Assert rst_n during READ with busy[5]=1 → immediately op_valid=0, busy=0, rf_rs1=rf_rs2=0, state IDLE.
